// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared state, width and slice types for the 3x3 column window former
package win_pkg;

  localparam int LEN     = 3;
  localparam int SLICE_W = 2 * LEN;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} win_state_t;

  typedef logic [SLICE_W-1:0] slice_t;

endpackage

// File: rtl/win_ring_ram.sv
// rtl/win_ring_ram.sv - per-channel {left, centre} column store, async read / sync write
module win_ring_ram
  import win_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_sclk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  slice_t        wr_l,
  input  slice_t        wr_c,
  output slice_t        rd_l,
  output slice_t        rd_c
);

  logic [2*SLICE_W-1:0] mem [DEPTH];

  always_ff @(posedge i_sclk) begin
    if (wr_en) mem[addr] <= {wr_l, wr_c};
  end

  // read and write share the channel address, so a RUN cycle sees the old pair
  assign {rd_l, rd_c} = mem[addr];

endmodule

// File: rtl/window_col_3x3.sv
// rtl/window_col_3x3.sv - forms zero-padded 3x3 sign-bit windows per (column, channel)
// Optional sticky o_err port and its drop/truncation checks: `WINDOW_ERR_EN
module window_col_3x3
  import win_pkg::*;
#(
  parameter int SIZE    = 56,
  parameter int CHANNEL = 64
) (
  input  logic                 i_sclk,
  input  logic                 i_rst,
  input  logic                 i_vsync,
  input  logic                 i_hsync,
  input  logic                 i_reuse,
  input  logic                 i_valid,
  input  logic [SLICE_W-1:0]   i_tdata,
  output logic                 o_vsync,
  output logic                 o_hsync,
  output logic                 o_reuse,
  output logic                 o_valid,
  output logic [3*SLICE_W-1:0] o_window
`ifdef WINDOW_ERR_EN
  ,
  output logic                 o_err
`endif
);

  localparam int COL_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CH_W  = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SIZE - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL - 1);

  win_state_t           state, state_n, cur_state;
  logic [COL_W-1:0]     col, col_n, cur_col;
  logic [CH_W-1:0]      ch, ch_n, cur_ch;
  logic                 we;
  slice_t               wr_l, wr_c, rd_l, rd_c;
  logic [3*SLICE_W-1:0] window_n;
  logic                 valid_n, hsync_n, reuse_n;

  win_ring_ram #(.DEPTH(CHANNEL), .AW(CH_W)) u_ram (
    .i_sclk (i_sclk),
    .wr_en  (we),
    .addr   (cur_ch),
    .wr_l   (wr_l),
    .wr_c   (wr_c),
    .rd_l   (rd_l),
    .rd_c   (rd_c)
  );

  // hsync restarts the row before this cycle's slice is counted, so it lands at (0,0)
  always_comb begin
    cur_state = state;
    cur_col   = col;
    cur_ch    = ch;
    if (i_hsync) begin
      cur_state = FILL;
      cur_col   = '0;
      cur_ch    = '0;
    end
  end

  always_comb begin
    state_n  = cur_state;
    col_n    = cur_col;
    ch_n     = cur_ch;
    we       = 1'b0;
    wr_l     = '0;
    wr_c     = i_tdata;
    window_n = o_window;
    valid_n  = 1'b0;
    hsync_n  = 1'b0;
    reuse_n  = i_hsync ? i_reuse : o_reuse;

    case (cur_state)
      FILL: begin
        if (i_valid) begin
          we = 1'b1;
          if (cur_ch == CH_LAST) begin
            ch_n    = '0;
            col_n   = COL_ONE;
            state_n = RUN;
          end else begin
            ch_n = cur_ch + 1'b1;
          end
        end
      end
      RUN: begin
        if (i_valid) begin
          we       = 1'b1;
          wr_l     = rd_c;
          window_n = {rd_l, rd_c, i_tdata};
          valid_n  = 1'b1;
          hsync_n  = (cur_col == COL_ONE) && (cur_ch == '0);
          if (cur_ch == CH_LAST) begin
            ch_n = '0;
            if (cur_col == COL_LAST) state_n = FLUSH;
            else                     col_n   = cur_col + 1'b1;
          end else begin
            ch_n = cur_ch + 1'b1;
          end
        end
      end
      FLUSH: begin
        // right edge: last column's windows get a zero right slice, input ignored
        window_n = {rd_l, rd_c, {SLICE_W{1'b0}}};
        valid_n  = 1'b1;
        if (cur_ch == CH_LAST) begin
          ch_n    = '0;
          col_n   = '0;
          state_n = IDLE;
        end else begin
          ch_n = cur_ch + 1'b1;
        end
      end
      default: ;
    endcase

    if (i_vsync) begin
      state_n = IDLE;
      col_n   = '0;
      ch_n    = '0;
      we      = 1'b0;
      valid_n = 1'b0;
      hsync_n = 1'b0;
      reuse_n = o_reuse;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state    <= IDLE;
      col      <= '0;
      ch       <= '0;
      o_vsync  <= 1'b0;
      o_hsync  <= 1'b0;
      o_reuse  <= 1'b0;
      o_valid  <= 1'b0;
      o_window <= '0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      ch       <= ch_n;
      o_vsync  <= i_vsync;
      o_hsync  <= hsync_n;
      o_reuse  <= reuse_n;
      o_valid  <= valid_n;
      o_window <= window_n;
    end
  end

`ifdef WINDOW_ERR_EN
  // sticky: truncated row (hsync mid FILL/RUN) or slice arriving with nowhere to go
  always_ff @(posedge i_sclk) begin
    if (i_rst || i_vsync) begin
      o_err <= 1'b0;
    end else if ((i_hsync && (state == FILL || state == RUN)) ||
                 (i_valid && (cur_state == IDLE || cur_state == FLUSH))) begin
      o_err <= 1'b1;
    end
  end
`endif

endmodule
